// File: rtl/ram_arb_pkg.sv
// Shared types and RAM command encoding for the two-requester RAM command arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StWaitRd
  } state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  function automatic logic [9:0] ram_cmd(logic [1:0] op, logic [7:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant register advances only when upd_i is set.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (upd_i) last_d = gnt_o[1];
  end

  // Reset to 1 so requester 0 wins the first contested round.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Arbitrates two requesters onto one RAM command channel, expanding each transaction into
// the two-word command sequence and routing read data (or a timeout error) back to its owner.
module ram_cmd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 8,
  parameter int unsigned TMO_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        ram_rx_valid,
  output logic [9:0]  ram_din,
  input  logic [7:0]  ram_dout,
  input  logic        ram_tx_valid
);

  state_e state_q, state_d;

  logic             owner_q, owner_d;
  logic             wr_q, wr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic       ram_rx_valid_q, ram_rx_valid_d;
  logic [9:0] ram_din_q, ram_din_d;
  logic [1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_err_q, rsp_err_d;

  logic [1:0] grant;
  logic       accept;
  logic       owner_in;
  logic       wr_in;
  logic [7:0] addr_in;
  logic [7:0] wdata_in;
  logic       tmo_done;

  rr_arb2 u_rr_arb2 (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (req_valid),
    .upd_i (accept),
    .gnt_o (grant)
  );

  assign accept   = (state_q == StIdle) && (grant != 2'b00);
  assign owner_in = grant[1];
  assign wr_in    = req_wr[owner_in];
  assign addr_in  = owner_in ? req_addr[15:8] : req_addr[7:0];
  assign wdata_in = owner_in ? req_wdata[15:8] : req_wdata[7:0];
  assign tmo_done = (tmo_q == TMO_W'(RD_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StAddr;
      StAddr:   state_d = StData;
      StData:   state_d = wr_q ? StIdle : StWaitRd;
      StWaitRd: if (ram_tx_valid || tmo_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      owner_d = owner_in;
      wr_d    = wr_in;
      addr_d  = addr_in;
      wdata_d = wdata_in;
    end
    tmo_d = (state_q == StWaitRd) ? tmo_q + TMO_W'(1) : '0;
  end

  // Output next-state is computed one state ahead so the RAM sees commands in cycles 1 and 2.
  always_comb begin
    req_ready      = (state_q == StIdle) ? grant : 2'b00;
    ram_rx_valid_d = 1'b0;
    ram_din_d      = ram_din_q;
    rsp_valid_d    = 2'b00;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          ram_rx_valid_d = 1'b1;
          ram_din_d      = ram_cmd(wr_in ? OP_WR_ADDR : OP_RD_ADDR, addr_in);
        end
      end
      StAddr: begin
        ram_rx_valid_d = 1'b1;
        ram_din_d      = wr_q ? ram_cmd(OP_WR_DATA, wdata_q) : ram_cmd(OP_RD_DATA, 8'h00);
      end
      StWaitRd: begin
        if (ram_tx_valid) begin
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_rdata_d = ram_dout;
        end else if (tmo_done) begin
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q        <= 1'b0;
      wr_q           <= 1'b0;
      addr_q         <= 8'h00;
      wdata_q        <= 8'h00;
      tmo_q          <= '0;
      ram_rx_valid_q <= 1'b0;
      ram_din_q      <= 10'h000;
      rsp_valid_q    <= 2'b00;
      rsp_rdata_q    <= 8'h00;
      rsp_err_q      <= 1'b0;
    end else begin
      owner_q        <= owner_d;
      wr_q           <= wr_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      tmo_q          <= tmo_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      ram_din_q      <= ram_din_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign ram_rx_valid = ram_rx_valid_q;
  assign ram_din      = ram_din_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter with a small behavioural RAM on the command channel.
module tb_ram_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_wr = 2'b00;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        ram_rx_valid;
  logic [9:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        ram_tx_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_cmd_arbiter #(
    .RD_TIMEOUT (8),
    .TMO_W      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .ram_rx_valid (ram_rx_valid),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid)
  );

  // Behavioural RAM: read data appears the cycle after the read-trigger command.
  logic [7:0] mem [256];
  logic [7:0] ram_addr_q = 8'h00;
  logic       model_tx_q = 1'b0;
  logic [7:0] model_dout_q = 8'h00;
  logic       ram_en = 1'b1;
  logic       stray = 1'b0;

  always @(posedge clk) begin
    model_tx_q <= 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00, 2'b10: ram_addr_q <= ram_din[7:0];
        2'b01:        mem[ram_addr_q] <= ram_din[7:0];
        default: begin
          model_tx_q   <= 1'b1;
          model_dout_q <= mem[ram_addr_q];
        end
      endcase
    end
  end

  assign ram_tx_valid = (model_tx_q & ram_en) | stray;
  assign ram_dout     = model_dout_q;

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (ram_rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid: got %b want 0", ram_rx_valid); end
    n_vec++; if (ram_din !== 10'h000) begin n_err++; $display("FAIL rst_din: got %h want 000", ram_din); end
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
    n_vec++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rsp_rdata: got %h want 00", rsp_rdata); end
    n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_ready_idle: got %b want 00", req_ready); end
    req_valid = 2'b11;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rst_first_grant: got %b want 01", req_ready); end
    req_valid = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_write();
    next_cyc();
    req_valid = 2'b01; req_wr = 2'b01; req_addr = 16'h003C; req_wdata = 16'h00A5;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL wr_ready: got %b want 01", req_ready); end
    next_cyc();
    req_valid = 2'b00;
    #1;
    n_vec++; if (ram_rx_valid !== 1'b1 || ram_din !== 10'h03C) begin
      n_err++; $display("FAIL wr_cmd1: got %b/%h want 1/03C", ram_rx_valid, ram_din); end
    n_vec++; if (busy !== 1'b1 || req_ready !== 2'b00) begin
      n_err++; $display("FAIL wr_busy1: got busy %b ready %b want 1/00", busy, req_ready); end
    next_cyc();
    n_vec++; if (ram_rx_valid !== 1'b1 || ram_din !== 10'h1A5) begin
      n_err++; $display("FAIL wr_cmd2: got %b/%h want 1/1A5", ram_rx_valid, ram_din); end
    next_cyc();
    n_vec++; if (busy !== 1'b0 || ram_rx_valid !== 1'b0 || ram_din !== 10'h1A5) begin
      n_err++; $display("FAIL wr_done: got busy %b rx %b din %h want 0/0/1A5", busy, ram_rx_valid, ram_din); end
  endtask

  task automatic test_read();
    req_valid = 2'b10; req_wr = 2'b00; req_addr = 16'h3C00;
    #1;
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL rd_ready: got %b want 10", req_ready); end
    next_cyc();
    req_valid = 2'b00;
    #1;
    n_vec++; if (ram_rx_valid !== 1'b1 || ram_din !== 10'h23C) begin
      n_err++; $display("FAIL rd_cmd1: got %b/%h want 1/23C", ram_rx_valid, ram_din); end
    next_cyc();
    n_vec++; if (ram_rx_valid !== 1'b1 || ram_din !== 10'h300) begin
      n_err++; $display("FAIL rd_cmd2: got %b/%h want 1/300", ram_rx_valid, ram_din); end
    next_cyc();
    n_vec++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
      n_err++; $display("FAIL rd_wait: got rsp %b busy %b want 00/1", rsp_valid, busy); end
    next_cyc();
    n_vec++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL rd_rsp: got %b/%h/%b want 10/A5/0", rsp_valid, rsp_rdata, rsp_err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_idle: got busy %b want 0", busy); end
    next_cyc();
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rd_pulse: got %b want 00", rsp_valid); end
  endtask

  task automatic test_timeout();
    ram_en = 1'b0;
    req_valid = 2'b01; req_wr = 2'b00; req_addr = 16'h0055;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL tmo_ready: got %b want 01", req_ready); end
    for (int c = 1; c <= 10; c++) begin
      next_cyc();
      req_valid = 2'b00;
      #1;
      n_vec++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
        n_err++; $display("FAIL tmo_wait_c%0d: got rsp %b busy %b want 00/1", c, rsp_valid, busy); end
    end
    next_cyc();
    ram_en = 1'b1;
    req_valid = 2'b10; req_wr = 2'b00; req_addr = 16'h3C00;
    #1;
    n_vec++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h00 || rsp_err !== 1'b1) begin
      n_err++; $display("FAIL tmo_rsp: got %b/%h/%b want 01/00/1", rsp_valid, rsp_rdata, rsp_err); end
    n_vec++; if (busy !== 1'b0 || req_ready !== 2'b10) begin
      n_err++; $display("FAIL tmo_next_accept: got busy %b ready %b want 0/10", busy, req_ready); end
    next_cyc();
    req_valid = 2'b00;
    #1;
    n_vec++; if (ram_din !== 10'h23C || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL tmo_next_cmd: got din %h err %b want 23C/0", ram_din, rsp_err); end
    next_cyc();
    next_cyc();
    next_cyc();
    n_vec++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL tmo_next_rsp: got %b/%h/%b want 10/A5/0", rsp_valid, rsp_rdata, rsp_err); end
    next_cyc();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b10; req_wr = 2'b00; req_addr = 16'h3C00;
    next_cyc();
    req_valid = 2'b00;
    next_cyc();
    n_vec++; if (ram_din !== 10'h300 || ram_rx_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_in_data: got %b/%h want 1/300", ram_rx_valid, ram_din); end
    rst = 1'b1;
    #1;
    n_vec++; if (ram_rx_valid !== 1'b0 || busy !== 1'b0 || ram_din !== 10'h000) begin
      n_err++; $display("FAIL mid_async: got rx %b busy %b din %h want 0/0/000", ram_rx_valid, busy, ram_din); end
    req_valid = 2'b11; req_wr = 2'b11;
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      n_vec++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        n_err++; $display("FAIL mid_hold_c%0d: got rsp %b busy %b want 00/0", c, rsp_valid, busy); end
    end
    rst = 1'b0;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_first_grant: got %b want 01", req_ready); end
    req_valid = 2'b00;
    next_cyc();
    n_vec++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_after: got rsp %b busy %b want 00/0", rsp_valid, busy); end
  endtask

  task automatic test_stray();
    stray = 1'b1;
    next_cyc();
    stray = 1'b0;
    #1;
    n_vec++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      n_err++; $display("FAIL stray_idle: got rsp %b busy %b want 00/0", rsp_valid, busy); end
    req_valid = 2'b01; req_wr = 2'b01; req_addr = 16'h003C; req_wdata = 16'h00A5; stray = 1'b1;
    next_cyc();
    req_valid = 2'b00;
    #1;
    n_vec++; if (ram_din !== 10'h03C || rsp_valid !== 2'b00) begin
      n_err++; $display("FAIL stray_addr: got din %h rsp %b want 03C/00", ram_din, rsp_valid); end
    next_cyc();
    stray = 1'b0;
    #1;
    n_vec++; if (ram_din !== 10'h1A5 || ram_rx_valid !== 1'b1 || rsp_valid !== 2'b00 || busy !== 1'b1) begin
      n_err++; $display("FAIL stray_data: got din %h rx %b rsp %b busy %b want 1A5/1/00/1",
                        ram_din, ram_rx_valid, rsp_valid, busy); end
    next_cyc();
    n_vec++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || ram_rx_valid !== 1'b0) begin
      n_err++; $display("FAIL stray_done: got busy %b rsp %b rx %b want 0/00/0", busy, rsp_valid, ram_rx_valid); end
  endtask

  task automatic test_alternate();
    int g0 = 0;
    int g1 = 0;
    logic [1:0] exp_rdy;
    logic [9:0] exp_din;
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    req_valid = 2'b11; req_wr = 2'b11; req_addr = 16'h2010; req_wdata = 16'h2111;
    for (int c = 0; c < 24; c++) begin
      #1;
      exp_rdy = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 1) ? 2'b10 : 2'b01);
      n_vec++; if (req_ready !== exp_rdy) begin
        n_err++; $display("FAIL alt_ready_c%0d: got %b want %b", c, req_ready, exp_rdy); end
      if (req_ready === 2'b01) g0++;
      if (req_ready === 2'b10) g1++;
      if (c % 3 == 1) begin
        exp_din = ((c / 3) % 2 == 1) ? 10'h020 : 10'h010;
        n_vec++; if (ram_din !== exp_din) begin
          n_err++; $display("FAIL alt_din_c%0d: got %h want %h", c, ram_din, exp_din); end
      end
      next_cyc();
    end
    n_vec++; if (g0 != 4 || g1 != 4) begin
      n_err++; $display("FAIL alt_counts: got %0d/%0d want 4/4", g0, g1); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy;
    req_valid = 2'b01; req_wr = 2'b01; req_addr = 16'h0077; req_wdata = 16'h0088;
    for (int c = 0; c < 9; c++) begin
      #1;
      exp_rdy = (c % 3 == 0) ? 2'b01 : 2'b00;
      n_vec++; if (req_ready !== exp_rdy) begin
        n_err++; $display("FAIL b2b_ready_c%0d: got %b want %b", c, req_ready, exp_rdy); end
      next_cyc();
    end
    req_valid = 2'b00;
    next_cyc();
    next_cyc();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got busy %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_reset_mid();
    test_stray();
    test_alternate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
